// File: rtl/pwl_act_unit.sv
// Pipelined piecewise-linear activation: runtime-writable segment table, signed
// input split into segment index and fraction, 3-stage interpolation with valid/ready.
module pwl_act_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  input  logic              lut_we,
  input  logic [ADDR_W-1:0] lut_waddr,
  input  logic [OUT_W-1:0]  lut_wdata
);

  localparam int FRAC_W = DATA_W - ADDR_W;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int PROD_W = OUT_W + FRAC_W + 2;
  localparam logic [ADDR_W-1:0] TOP_IDX = ADDR_W'((2 ** (ADDR_W - 1)) - 1);

  // Reset table content: signed index scaled to the top of the output range.
  function automatic logic [OUT_W-1:0] ramp_entry(input int unsigned idx);
    logic [OUT_W-1:0] v;
    v = OUT_W'(idx) << (OUT_W - ADDR_W);
    return v;
  endfunction

  logic [OUT_W-1:0] lut_q [DEPTH];

  logic [ADDR_W-1:0] addr_s, next_s;
  logic [FRAC_W-1:0] frac_s;
  logic              advance_s, accept_s;

  logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [OUT_W-1:0]         base1_q, base1_d, nxt1_q, nxt1_d;
  logic [FRAC_W-1:0]        frac1_q, frac1_d;
  logic [OUT_W-1:0]         base2_q, base2_d;
  logic signed [PROD_W-1:0] prod2_q, prod2_d;
  logic [OUT_W-1:0]         y3_q, y3_d;

  logic signed [OUT_W:0]    diff_s;
  logic signed [PROD_W-1:0] diff_ext_s, frac_ext_s, prod_s, base_ext_s;

  assign advance_s = !v3_q || out_ready;
  assign accept_s  = in_valid && advance_s;
  assign in_ready  = advance_s;
  assign out_valid = v3_q;
  assign out_data  = y3_q;

  // Segment table: reset reloads the ramp; writes land on the clock edge (reads see old data).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        lut_q[i] <= ramp_entry(i);
      end
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  // Decode input into segment index and fraction; the most positive segment is held flat.
  always_comb begin
    addr_s = in_data[DATA_W-1 -: ADDR_W];
    frac_s = in_data[FRAC_W-1:0];
    if (addr_s == TOP_IDX) begin
      next_s = addr_s;
    end else begin
      next_s = addr_s + ADDR_W'(1);
    end
  end

  // Interpolation arithmetic: widen so diff*frac never overflows before the floor shift.
  always_comb begin
    diff_s     = $signed({nxt1_q[OUT_W-1], nxt1_q}) - $signed({base1_q[OUT_W-1], base1_q});
    diff_ext_s = {{(PROD_W - OUT_W - 1){diff_s[OUT_W]}}, diff_s};
    frac_ext_s = {{(PROD_W - FRAC_W){1'b0}}, frac1_q};
    prod_s     = diff_ext_s * frac_ext_s;
    base_ext_s = {{(PROD_W - OUT_W){base2_q[OUT_W-1]}}, base2_q};
  end

  // Next-state for the three stages; everything holds while the output is stalled.
  always_comb begin
    v1_d    = v1_q;
    base1_d = base1_q;
    nxt1_d  = nxt1_q;
    frac1_d = frac1_q;
    v2_d    = v2_q;
    base2_d = base2_q;
    prod2_d = prod2_q;
    v3_d    = v3_q;
    y3_d    = y3_q;
    if (advance_s) begin
      v1_d    = accept_s;
      base1_d = lut_q[addr_s];
      nxt1_d  = lut_q[next_s];
      frac1_d = frac_s;
      v2_d    = v1_q;
      base2_d = base1_q;
      prod2_d = prod_s;
      v3_d    = v2_q;
      if (v2_q) begin
        y3_d = OUT_W'(base_ext_s + (prod2_q >>> FRAC_W));
      end else begin
        y3_d = y3_q;
      end
    end else begin
      v1_d = v1_q;
    end
  end

  // Pipeline registers; reset drops every in-flight sample and clears the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      base1_q <= '0;
      nxt1_q  <= '0;
      frac1_q <= '0;
      base2_q <= '0;
      prod2_q <= '0;
      y3_q    <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      base1_q <= base1_d;
      nxt1_q  <= nxt1_d;
      frac1_q <= frac1_d;
      base2_q <= base2_d;
      prod2_q <= prod2_d;
      y3_q    <= y3_d;
    end
  end

endmodule

// File: tb/tb_pwl_act_unit.sv
// Self-checking bench for pwl_act_unit: vector table plus scoreboard queue,
// with hand-written sequences for latency, backpressure, table writes and reset.
module tb_pwl_act_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       lut_we;
  logic [3:0] lut_waddr;
  logic [7:0] lut_wdata;

  always #5 clk = ~clk;

  pwl_act_unit #(.DATA_W(8), .ADDR_W(4), .OUT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
  } vec_t;

  vec_t       vecs [10];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_deliv = 0;
  int         cyc     = 0;
  int         ready_mode = 0;
  logic [7:0] exp_q [$];
  logic [7:0] lut_m [16];
  logic [7:0] cur_exp;
  logic       acc_last;
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] x);
    logic [3:0] a, nx;
    int b, nv, f, p, y;
    a  = x[7:4];
    nx = (a == 4'd7) ? a : a + 4'd1;
    b  = $signed(lut_m[a]);
    nv = $signed(lut_m[nx]);
    f  = int'(x[3:0]);
    p  = (nv - b) * f;
    y  = b + (p >>> 4);
    return y[7:0];
  endfunction

  // One clock: drive out_ready, check outputs mid-low-phase, step scoreboard, advance.
  task automatic step();
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ((cyc % 3) == 0);
      2: out_ready = 1'($urandom_range(0, 1));
      3: out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
    cyc++;
    #1;
    acc_last = 1'b0;
    if (!rst) begin
      check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_hold", 32'(out_data), 32'(data_prev));
      end
      if (out_valid && out_ready) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got out_data=%0h, required no output", out_data);
        end else begin
          check("result", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      acc_last = in_valid && in_ready;
      if (acc_last) exp_q.push_back(cur_exp);
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
    end else begin
      stall_prev = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    int n;
    in_valid = 1'b1;
    in_data  = x;
    cur_exp  = y;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc_last && n < 50);
    if (!acc_last) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept for x=%0h, required accept within 50 cycles", x);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    logic [7:0] x;

    vecs[0] = '{8'h25, 8'd37};
    vecs[1] = '{8'hC3, 8'hC3};
    vecs[2] = '{8'h70, 8'd112};
    vecs[3] = '{8'h78, 8'd112};
    vecs[4] = '{8'h7F, 8'd112};
    vecs[5] = '{8'hFF, 8'hFF};
    vecs[6] = '{8'h80, 8'h80};
    vecs[7] = '{8'h00, 8'h00};
    vecs[8] = '{8'h6F, 8'd111};
    vecs[9] = '{8'h10, 8'd16};
    for (int i = 0; i < 16; i++) lut_m[i] = 8'(i << 4);

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    lut_we = 1'b0; lut_waddr = 4'd0; lut_wdata = 8'h00; cur_exp = 8'h00;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Latency from accept to out_valid, unstalled.
    send(8'h25, 8'd37);
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    drain();

    // Vector table streamed back-to-back against the reset ramp.
    for (int i = 0; i < 10; i++) send(vecs[i].x, vecs[i].y);
    drain();

    // Backpressure with out_ready pattern 1,0,0,...
    ready_mode = 1;
    n_deliv = 0;
    send(8'h05, 8'h05); send(8'hF0, 8'hF0); send(8'h33, 8'h33);
    send(8'hA7, 8'hA7); send(8'h4C, 8'h4C); send(8'hD9, 8'hD9);
    drain();
    check("bp_count", 32'(n_deliv), 32'd6);
    ready_mode = 0;

    // Write lut[1]=100 in the same cycle x=0x18 is accepted: old table, then new.
    in_valid = 1'b1; in_data = 8'h18; cur_exp = 8'd24;
    lut_we = 1'b1; lut_waddr = 4'd1; lut_wdata = 8'd100;
    step();
    check("rbw_accept", 32'(acc_last), 32'd1);
    lut_we = 1'b0;
    lut_m[1] = 8'd100;
    cur_exp = 8'd66;
    step();
    check("rbw_accept2", 32'(acc_last), 32'd1);
    in_valid = 1'b0;
    drain();

    // Random table and random traffic against the model.
    for (int i = 0; i < 16; i++) begin
      if (i != 1) begin
        lut_we = 1'b1; lut_waddr = 4'(i); lut_wdata = 8'($urandom);
        lut_m[i] = lut_wdata;
        step();
      end
    end
    lut_we = 1'b0;
    ready_mode = 2;
    for (int i = 0; i < 24; i++) begin
      x = 8'($urandom);
      send(x, model(x));
    end
    drain();

    // Reset with three samples in flight and a modified table.
    ready_mode = 3;
    send(8'h11, 8'h00); send(8'h22, 8'h00); send(8'h33, 8'h00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) lut_m[i] = 8'(i << 4);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    ready_mode = 0;
    for (int i = 0; i < 5; i++) step();
    send(8'h18, 8'd24);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
